// File: rtl/prn_free_list_if.sv
// Rename-stage <-> free-list bundle: allocation request/grant, ROB frees,
// checkpoint/rollback controls and status.
interface prn_free_list_if #(
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3
);
  localparam int CNT_BITS = PRN_BITS + 1;
  localparam int REQ_BITS = $clog2(MAX_OPERANDS + 1);

  // Handshake: alloc_req is a valid, alloc_grant its combinational ready;
  // the allocation commits on a posedge where both are high (no retention
  // required of the renamer). free_valid[i] is a ready-less strobe: each
  // slot marked valid is consumed at the posedge unconditionally.
  logic                                   alloc_req;
  logic [REQ_BITS-1:0]                    alloc_count;
  logic                                   alloc_grant;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  alloc_prns;
  logic [MAX_OPERANDS-1:0]                free_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  free_prns;
  logic                                   ckpt_save;
  logic                                   rollback;
  logic [CNT_BITS-1:0]                    free_count;
  logic                                   stall;
  logic                                   overflow_err;

  modport master (
    output alloc_req, alloc_count, free_valid, free_prns, ckpt_save, rollback,
    input  alloc_grant, alloc_prns, free_count, stall, overflow_err
  );

  modport slave (
    input  alloc_req, alloc_count, free_valid, free_prns, ckpt_save, rollback,
    output alloc_grant, alloc_prns, free_count, stall, overflow_err
  );
endinterface

// File: rtl/prn_free_list.sv
// Physical-register free list: circular ring of free PRNs with all-or-nothing
// multi-allocation, compacted multi-free, and a single head checkpoint.
module prn_free_list #(
  parameter int PRN_BITS     = 6,
  parameter int ARCH_REGS    = 32,
  parameter int MAX_OPERANDS = 3
) (
  input  logic           clk,
  input  logic           rst,
  prn_free_list_if.slave bus
);
  localparam int CNT_BITS = PRN_BITS + 1;
  localparam int SUM_BITS = CNT_BITS + 1;
  localparam int DEPTH    = 1 << PRN_BITS;

  logic [PRN_BITS-1:0] ring_q [DEPTH];
  logic [CNT_BITS-1:0] head_q, head_d;
  logic [CNT_BITS-1:0] tail_q, tail_d;
  logic [CNT_BITS-1:0] ckpt_q, ckpt_d;
  logic                ovf_q, ovf_d;

  logic [CNT_BITS-1:0] free_cnt;
  logic                grant;
  logic                alloc_fire;
  logic [PRN_BITS-1:0] pop;
  logic [PRN_BITS-1:0] ofs;
  logic [SUM_BITS-1:0] need;
  logic                ovf_hit;
  logic [MAX_OPERANDS-1:0]               wr_en;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] wr_idx;

  always_comb begin
    free_cnt   = tail_q - head_q;
    grant      = ~bus.rollback & (free_cnt >= CNT_BITS'(bus.alloc_count));
    alloc_fire = bus.alloc_req & grant;

    for (int i = 0; i < MAX_OPERANDS; i++) begin
      bus.alloc_prns[i] = ring_q[head_q[PRN_BITS-1:0] + PRN_BITS'(i)];
    end

    // Compact valid free slots: each valid slot lands at tail + (valid slots below it).
    ofs = '0;
    for (int i = 0; i < MAX_OPERANDS; i++) begin
      wr_idx[i] = tail_q[PRN_BITS-1:0] + ofs;
      if (bus.free_valid[i]) ofs = ofs + 1'b1;
    end
    pop = ofs;

    need    = {1'b0, free_cnt} + SUM_BITS'(pop)
              - (alloc_fire ? SUM_BITS'(bus.alloc_count) : '0);
    ovf_hit = need > SUM_BITS'(DEPTH);

    for (int i = 0; i < MAX_OPERANDS; i++) begin
      wr_en[i] = bus.free_valid[i] & ~ovf_hit;
    end

    head_d = head_q;
    if (bus.rollback)    head_d = ckpt_q;
    else if (alloc_fire) head_d = head_q + CNT_BITS'(bus.alloc_count);

    tail_d = ovf_hit ? tail_q : tail_q + CNT_BITS'(pop);
    // Snapshot is the pre-allocation head; a same-cycle rollback suppresses it.
    ckpt_d = (bus.ckpt_save & ~bus.rollback) ? head_q : ckpt_q;
    ovf_d  = ovf_q | ovf_hit;

    bus.alloc_grant  = grant;
    bus.stall        = bus.alloc_req & ~grant;
    bus.free_count   = free_cnt;
    bus.overflow_err = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= CNT_BITS'(DEPTH - ARCH_REGS);
      ckpt_q <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ring_q[i] <= (i < DEPTH - ARCH_REGS) ? PRN_BITS'(ARCH_REGS + i) : '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      ckpt_q <= ckpt_d;
      ovf_q  <= ovf_d;
      for (int i = 0; i < MAX_OPERANDS; i++) begin
        if (wr_en[i]) ring_q[wr_idx[i]] <= bus.free_prns[i];
      end
    end
  end
endmodule

// File: tb/tb_prn_free_list.sv
// Directed bench for prn_free_list: driver pushes expected outputs into a
// queue, a negedge monitor pops and compares them.
module tb_prn_free_list;
  localparam int W = 31;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_miss;
  logic [W-1:0] exp_q[$];
  logic [5:0]   fq[$];

  prn_free_list_if #(.PRN_BITS(6), .MAX_OPERANDS(3)) bus ();

  prn_free_list #(.PRN_BITS(6), .ARCH_REGS(32), .MAX_OPERANDS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(1'b0, 2'd0, 3'b000, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
  endtask

  // driver
  task automatic drive(input logic req, input logic [1:0] cnt, input logic [2:0] fv,
                       input logic [5:0] f0, input logic [5:0] f1, input logic [5:0] f2,
                       input logic save, input logic rb);
    bus.alloc_req   = req;
    bus.alloc_count = cnt;
    bus.free_valid  = fv;
    bus.free_prns[0] = f0;
    bus.free_prns[1] = f1;
    bus.free_prns[2] = f2;
    bus.ckpt_save   = save;
    bus.rollback    = rb;
  endtask

  // layout: {mask[2:0], p2, p1, p0, ovf, free_count[6:0], stall, grant}
  task automatic expect_o(input logic g, input logic st, input logic [6:0] fc,
                          input logic [2:0] m, input logic [5:0] p0,
                          input logic [5:0] p1, input logic [5:0] p2, input logic ovf);
    exp_q.push_back({m, p2, p1, p0, ovf, fc, st, g});
  endtask

  // scoreboard monitor
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp("alloc_grant", 32'(bus.alloc_grant), 32'(e[0]));
      cmp("stall", 32'(bus.stall), 32'(e[1]));
      cmp("free_count", 32'(bus.free_count), 32'(e[8:2]));
      cmp("overflow_err", 32'(bus.overflow_err), 32'(e[9]));
      if (e[28]) cmp("alloc_prns0", 32'(bus.alloc_prns[0]), 32'(e[15:10]));
      if (e[29]) cmp("alloc_prns1", 32'(bus.alloc_prns[1]), 32'(e[21:16]));
      if (e[30]) cmp("alloc_prns2", 32'(bus.alloc_prns[2]), 32'(e[27:22]));
    end
  end

  initial begin
    logic [5:0] p [3];
    logic [5:0] v [3];
    n_cmp  = 0;
    n_miss = 0;
    do_reset();

    // reset then idle
    drive(0, 0, 3'b000, 0, 0, 0, 0, 0);
    expect_o(1, 0, 32, 3'b111, 32, 33, 34, 0); tick();

    // drain 30 entries
    for (int k = 0; k < 10; k++) begin
      drive(1, 3, 3'b000, 0, 0, 0, 0, 0);
      expect_o(1, 0, 7'(32 - 3 * k), 3'b111, 6'(32 + 3 * k), 6'(33 + 3 * k), 6'(34 + 3 * k), 0);
      tick();
    end
    drive(1, 3, 3'b000, 0, 0, 0, 0, 0);
    expect_o(0, 1, 2, 3'b011, 62, 63, 0, 0); tick();
    drive(1, 2, 3'b000, 0, 0, 0, 0, 0);
    expect_o(1, 0, 2, 3'b011, 62, 63, 0, 0); tick();
    drive(1, 1, 3'b000, 0, 0, 0, 0, 0);
    expect_o(0, 1, 0, 3'b000, 0, 0, 0, 0); tick();
    drive(1, 0, 3'b000, 0, 0, 0, 0, 0);
    expect_o(1, 0, 0, 3'b000, 0, 0, 0, 0); tick();

    // refill 2, then alloc 2 with simultaneous compacted free
    drive(0, 0, 3'b011, 40, 41, 0, 0, 0);
    expect_o(1, 0, 0, 3'b000, 0, 0, 0, 0); tick();
    drive(1, 2, 3'b101, 5, 0, 9, 0, 0);
    expect_o(1, 0, 2, 3'b011, 40, 41, 0, 0); tick();
    drive(0, 0, 3'b000, 0, 0, 0, 0, 0);
    expect_o(1, 0, 2, 3'b011, 5, 9, 0, 0); tick();

    // wrap: allocate and free 3 per cycle, issued order must match freed order
    do_reset();
    fq.delete();
    for (int i = 0; i < 32; i++) fq.push_back(6'(32 + i));
    for (int k = 0; k < 50; k++) begin
      for (int j = 0; j < 3; j++) begin
        p[j] = fq.pop_front();
        v[j] = 6'(((k * 3 + j) * 5) % 64);
      end
      drive(1, 3, 3'b111, v[0], v[1], v[2], 0, 0);
      expect_o(1, 0, 32, 3'b111, p[0], p[1], p[2], 0);
      for (int j = 0; j < 3; j++) fq.push_back(v[j]);
      tick();
    end

    // checkpoint and rollback
    do_reset();
    drive(1, 3, 3'b000, 0, 0, 0, 1, 0);
    expect_o(1, 0, 32, 3'b111, 32, 33, 34, 0); tick();
    drive(1, 3, 3'b000, 0, 0, 0, 0, 0);
    expect_o(1, 0, 29, 3'b111, 35, 36, 37, 0); tick();
    drive(1, 1, 3'b000, 0, 0, 0, 0, 1);
    expect_o(0, 1, 26, 3'b001, 38, 0, 0, 0); tick();
    drive(0, 0, 3'b000, 0, 0, 0, 0, 0);
    expect_o(1, 0, 32, 3'b111, 32, 33, 34, 0); tick();
    drive(0, 0, 3'b111, 1, 2, 3, 0, 1);
    expect_o(0, 0, 32, 3'b000, 0, 0, 0, 0); tick();
    drive(1, 3, 3'b000, 0, 0, 0, 0, 0);
    expect_o(1, 0, 35, 3'b111, 32, 33, 34, 0); tick();
    drive(0, 0, 3'b000, 0, 0, 0, 1, 1);
    expect_o(0, 0, 32, 3'b000, 0, 0, 0, 0); tick();
    drive(1, 3, 3'b000, 0, 0, 0, 0, 0);
    expect_o(1, 0, 35, 3'b111, 32, 33, 34, 0); tick();
    drive(0, 0, 3'b000, 0, 0, 0, 0, 1);
    expect_o(0, 0, 32, 3'b000, 0, 0, 0, 0); tick();
    drive(0, 0, 3'b000, 0, 0, 0, 0, 0);
    expect_o(1, 0, 35, 3'b111, 32, 33, 34, 0); tick();

    // overflow
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 3'b111, 6'(3 * k), 6'(3 * k + 1), 6'(3 * k + 2), 0, 0);
      expect_o(1, 0, 7'(32 + 3 * k), 3'b000, 0, 0, 0, 0);
      tick();
    end
    drive(0, 0, 3'b011, 30, 31, 0, 0, 0);
    expect_o(1, 0, 62, 3'b000, 0, 0, 0, 0); tick();
    drive(0, 0, 3'b001, 50, 0, 0, 0, 0);
    expect_o(1, 0, 64, 3'b000, 0, 0, 0, 0); tick();
    drive(1, 3, 3'b111, 10, 11, 12, 0, 0);
    expect_o(1, 0, 64, 3'b111, 32, 33, 34, 1); tick();
    drive(0, 0, 3'b000, 0, 0, 0, 0, 0);
    expect_o(1, 0, 64, 3'b111, 35, 36, 37, 1); tick();
    do_reset();
    drive(0, 0, 3'b000, 0, 0, 0, 0, 0);
    expect_o(1, 0, 32, 3'b111, 32, 33, 34, 0); tick();

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end
endmodule
